// File: rtl/pcap_replay_queue_arbiter.sv
// Packet-granular round-robin arbiter: merges per-queue packet FIFOs onto the
// single replay-memory writer port, locking the grant for a whole packet.
module pcap_replay_queue_arbiter #(
    parameter int unsigned FIFO_DATA_WIDTH = 72,
    parameter int unsigned FIFO_NUM_QUEUES = 4,
    parameter int unsigned QID_WIDTH       = $clog2(FIFO_NUM_QUEUES),
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   sw_rst,
    input  logic [FIFO_NUM_QUEUES*FIFO_DATA_WIDTH-1:0] in_data,
    input  logic [FIFO_NUM_QUEUES-1:0]             in_eop,
    input  logic [FIFO_NUM_QUEUES-1:0]             in_empty,
    output logic [FIFO_NUM_QUEUES-1:0]             in_rd_en,
    input  logic [FIFO_NUM_QUEUES-1:0]             q_enable,
    output logic [FIFO_DATA_WIDTH-1:0]             fifo_data,
    output logic [QID_WIDTH-1:0]                   fifo_qid,
    output logic                                   fifo_empty,
    input  logic                                   fifo_rd_en,
    output logic [FIFO_NUM_QUEUES*CNT_WIDTH-1:0]   pkt_cnt,
    output logic                                   busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                                      state_q, state_d;
    logic [QID_WIDTH-1:0]                        grant_q, grant_d;
    logic [QID_WIDTH-1:0]                        last_q, last_d;
    logic [FIFO_NUM_QUEUES-1:0][CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic                                        busy_q, busy_d;

    logic [FIFO_NUM_QUEUES-1:0][FIFO_DATA_WIDTH-1:0] data_arr_c;
    logic [QID_WIDTH-1:0]                        sel_c;
    logic                                        pop_c;
    logic                                        found_c;
    logic [QID_WIDTH-1:0]                        pick_c;

    assign data_arr_c = in_data;
    assign pkt_cnt    = pkt_cnt_q;
    assign busy       = busy_q;

    // Merged FIFO view: granted queue while locked, parked on last otherwise.
    always_comb begin
        sel_c      = (state_q == ST_LOCKED) ? grant_q : last_q;
        fifo_data  = data_arr_c[sel_c];
        fifo_qid   = sel_c;
        fifo_empty = 1'b1;
        pop_c      = 1'b0;
        in_rd_en   = '0;
        if (state_q == ST_LOCKED) begin
            fifo_empty = in_empty[grant_q];
            pop_c      = fifo_rd_en && !in_empty[grant_q];
            in_rd_en[grant_q] = pop_c;
        end
    end

    // Round-robin search starting after the last served queue, last one checked last.
    always_comb begin
        logic [QID_WIDTH-1:0] cand;
        found_c = 1'b0;
        pick_c  = last_q;
        cand    = '0;
        for (int k = 1; k <= int'(FIFO_NUM_QUEUES); k++) begin
            cand = QID_WIDTH'((int'(last_q) + k) % int'(FIFO_NUM_QUEUES));
            if (!found_c && q_enable[cand] && !in_empty[cand]) begin
                found_c = 1'b1;
                pick_c  = cand;
            end
        end
    end

    // Next-state: grant on eligibility in IDLE, release on the EOP pop.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    state_d = ST_LOCKED;
                    grant_d = pick_c;
                end
            end
            ST_LOCKED: begin
                if (pop_c && in_eop[grant_q]) begin
                    state_d            = ST_IDLE;
                    last_d             = grant_q;
                    pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + CNT_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_LOCKED);
    end

    // State registers; hardware and software reset are equivalent and synchronous.
    always_ff @(posedge clk) begin
        if (rst || sw_rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= QID_WIDTH'(FIFO_NUM_QUEUES - 1);
            pkt_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            pkt_cnt_q <= pkt_cnt_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: doc/pcap_replay_queue_arbiter.md
# pcap_replay_queue_arbiter

Packet-granular round-robin scheduler that shares the single FIFO-side write port of the replay memory writer among FIFO_NUM_QUEUES per-queue input FIFOs. It sits between the per-queue packet FIFOs and the memory writer. It presents one merged FIFO interface (data, qid, empty) and steers the writer's pops back to the granted queue. The grant is locked for a whole packet, so each queue's memory region receives only contiguous, unmixed packets.

## Interface
- FIFO_DATA_WIDTH, 72, data word width per queue.
- FIFO_NUM_QUEUES, 4, number of requesting queues (2..4).
- QID_WIDTH, log2(FIFO_NUM_QUEUES), width of queue id.
- CNT_WIDTH, 32, width of per-queue packet counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- sw_rst  in  1  software reset; same effect as rst.
- in_data  in  FIFO_NUM_QUEUES*FIFO_DATA_WIDTH  head word of each queue; queue i occupies bits [(i+1)*W-1 : i*W].
- in_eop  in  FIFO_NUM_QUEUES  head word of queue i is the last word of its packet.
- in_empty  in  FIFO_NUM_QUEUES  queue i empty.
- in_rd_en  out  FIFO_NUM_QUEUES  pop strobe to queue i.
- q_enable  in  FIFO_NUM_QUEUES  queue i eligible for new grants.
- fifo_data  out  FIFO_DATA_WIDTH  merged head word.
- fifo_qid  out  QID_WIDTH  id of the granted queue.
- fifo_empty  out  1  merged empty.
- fifo_rd_en  in  1  pop from the memory writer.
- pkt_cnt  out  FIFO_NUM_QUEUES*CNT_WIDTH  packets forwarded per queue.
- busy  out  1  a grant is locked.

## Operation
- States: IDLE and LOCKED. Registers: grant (QID_WIDTH), last (QID_WIDTH), pkt_cnt[i].
- **IDLE**
  - Eligible queues: q_enable[i] && !in_empty[i].
  - Search order: last+1, last+2, … with wrap modulo FIFO_NUM_QUEUES; last itself is checked last.
  - The first eligible queue is registered as grant, and the state moves to LOCKED.
  - With no eligible queue, the block stays in IDLE.
- **LOCKED** (combinational outputs)
  - fifo_data = in_data[grant].
  - fifo_qid = grant.
  - fifo_empty = in_empty[grant].
  - in_rd_en[grant] = fifo_rd_en && !in_empty[grant]; all other in_rd_en bits are 0.
- **End of packet**: a pop with in_eop[grant]=1 sets last <= grant, increments pkt_cnt[grant], and returns the state to IDLE.
- **IDLE outputs**: fifo_empty=1, in_rd_en=0, fifo_data = in_data[last], fifo_qid = last.
- fifo_qid is held stable for the whole packet. The writer samples qid in both of its word phases, so this is mandatory.
- Deasserting q_enable while LOCKED does not break the packet. The packet completes, and the queue is skipped from the next arbitration onward.
- Granted queue runs empty mid-packet: the block stays LOCKED with fifo_empty=1 and waits. There is no timeout.
- fifo_rd_en while fifo_empty=1 is ignored: no pop, no state change.
- pkt_cnt wraps from 2^CNT_WIDTH-1 to 0.

## Timing
- Reset (rst or sw_rst, any state, including mid-packet):
  - state=IDLE, grant=0, last=FIFO_NUM_QUEUES-1 (so q0 wins first), pkt_cnt=0.
  - Outputs: fifo_empty=1, in_rd_en=0, busy=0, fifo_qid=FIFO_NUM_QUEUES-1.
  - A partially forwarded packet is abandoned; upstream FIFOs are reset by their owners.
- Arbitration latency: eligibility seen in cycle N gives LOCKED and fifo_empty=0 in cycle N+1.
- Pop path: fifo_rd_en to in_rd_en is purely combinational, zero latency.
- The EOP pop in cycle N gives IDLE in N+1 and a new grant at the earliest in N+2. This is a one-cycle arbitration bubble per packet.
- busy = (state==LOCKED), registered.
- pkt_cnt updates on the clock edge following the EOP pop.

## Test plan
- Single packet: reset, then q0 loaded with 3 words (EOP on word 3), writer pops every other cycle.
  - Required: fifo_qid=0 throughout, exactly 3 in_rd_en[0] pulses, pkt_cnt[0]=1, IDLE one cycle after the last pop.
- Round robin: all 4 queues hold two 2-word packets each.
  - Required: grant order 0,1,2,3,0,1,2,3; packets are never interleaved; each pkt_cnt=2.
- Enable mask: q_enable=4'b1010 with all queues non-empty.
  - Required: only q1 and q3 are granted, alternating; in_rd_en[0] and in_rd_en[2] are never asserted.
- Mid-packet underflow: q2 empties after word 1 of 4 for 10 cycles, with q0 non-empty.
  - Required: the block stays LOCKED on q2 with fifo_empty=1; q0 is not granted until q2's EOP pops.
- Reset mid-packet: sw_rst asserted while LOCKED on q3.
  - Required: next cycle IDLE, in_rd_en=0, all pkt_cnt=0; the next grant goes to q0 if it is eligible.
- Counter wrap: pkt_cnt[1] preloaded via force to 2^32-1, then one packet sent.
  - Required: pkt_cnt[1]=0.
